fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Instruction-fetch stage directly upstream of decode.
- Holds the fetch PC and issues word reads to the shared memory model over its enable/busy handshake.
- Buffers returned {pc, instruction} pairs in a small FIFO and presents them to decode.
- Consumes the execute stage's redirect (taken branch or jump, target out_pc), flushing wrong-path work.

Parameters:
RESET_PC, 32'h8002_0000, first fetch address after reset
BUF_DEPTH, 2, instruction buffer entries; power of two, at least 2

Ports:
clock  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
stall  in  1  decode cannot accept the head entry this cycle
redirect  in  1  execute resolved a taken branch or jump this cycle
redirect_pc  in  32  new fetch target (execute out_pc); bits [1:0] ignored, treated as 0
mem_address  out  32  word address of the outstanding read
mem_enable  out  1  read request active
mem_read_write  out  1  tied 1 (read); fetch never writes
mem_data_in  in  32  memory data_out
mem_busy  in  1  memory not yet ready
instr_out  out  32  head-entry instruction (0 when invalid)
pc_out  out  32  head-entry PC (0 when invalid)
instr_valid  out  1  head entry present

Behaviour:
- Reset: sampled on clock edge; overrides every other input, including mid-transaction.
  - fetch_pc <= RESET_PC; FIFO emptied; state <= REQ.
  - instr_valid=0, instr_out=0, pc_out=0; mem_enable=0 in the reset cycle.
- FSM states:
  - REQ: mem_enable=1, mem_address=fetch_pc; next state WAIT. Entered only when FIFO has a free slot, counting the entry being popped in the same cycle.
  - WAIT: mem_enable=1, address held. If mem_busy=0, capture {fetch_pc, mem_data_in} into the FIFO and set fetch_pc += 4 (wraps modulo 2^32). Then go to REQ if a slot remains, else FULL. If mem_busy=1, stay in WAIT.
  - FULL: mem_enable=0; go to REQ in the cycle after a pop.
  - DRAIN: mem_enable held 1 until mem_busy=0; the response is discarded; then REQ.
- Throughput: minimum 2 cycles per instruction; the first instruction is visible 2 cycles after reset deasserts when busy=0.
- Pop: occurs when instr_valid=1 and stall=0. The head advances at that clock edge.
- Redirect has priority over capture and pop in the same cycle.
  - FIFO flushed; fetch_pc <= {redirect_pc[31:2], 2'b00}; instr_valid=0 on the next cycle.
  - Redirect in WAIT with mem_busy=1: go to DRAIN. The in-flight read is never presented.
  - Redirect in WAIT with mem_busy=0: the returning word is dropped; go to REQ.
  - Redirect in REQ or FULL: go to REQ.
- Full FIFO with simultaneous pop and capture: legal; count unchanged.
- Empty FIFO: instr_valid=0; stall is ignored.
- mem_address is stable for the whole REQ/WAIT/DRAIN transaction.

Optional Feature:
FETCH_STATS_EN
- Defined: adds ports fetch_count (out, 32) and flush_count (out, 16).
  - fetch_count increments on every FIFO capture.
  - flush_count increments on every redirect that discards at least one buffered or in-flight instruction.
  - Both counters are cleared by reset and saturate at all-ones.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package mips_fetch_pkg: MEM_START constant (32'h8002_0000), INSTR_W=32, NOP_INSTR=32'h0, fetch state enum {REQ, WAIT, FULL, DRAIN}.
- Sub-module fetch_buffer: parameterised BUF_DEPTH FIFO of {pc, instr}.
  - Controls: push, pop, flush.
  - Outputs: full, empty, free_next.
  - flush has priority over push and pop.

Test Plan:
- Reset, then busy=0 and stall=0, memory holding 0x8C080000, 0x01094020, 0x08000000 -> instr_valid rises 2 cycles after reset; pc_out sequence 8002_0000, 8002_0004, 8002_0008 with matching instr_out.
- stall=1 held 10 cycles -> exactly BUF_DEPTH captures, then mem_enable=0 (FULL). Release stall -> one pop per cycle; fetch resumes at 8002_0008.
- mem_busy held 3 cycles per read -> mem_address constant during busy; word captured in the first busy=0 cycle; no duplicate entries.
- redirect=1, redirect_pc=8002_0043 while in WAIT with busy=1 -> DRAIN; stale word dropped; next valid entry pc_out=8002_0040.
- redirect in the same cycle as a pop and a capture -> FIFO empty next cycle; no pre-redirect PC ever reappears.
- reset asserted mid-WAIT -> next cycle instr_valid=0 and mem_enable=0; then a REQ to 8002_0000. With FETCH_STATS_EN defined, both counters read 0.

Source files
------------

// File: rtl/mips_fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_fetch_pkg
//  Description : Shared constants and state encoding for the fetch stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package mips_fetch_pkg;

    // Boot address of the instruction image
    localparam logic [31:0] MEM_START = 32'h8002_0000;

    // Instruction / address word width
    localparam int INSTR_W = 32;

    // Value presented on the instruction bus when nothing is valid
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    // Fetch sequencer states
    typedef enum logic [1:0] {
        REQ   = 2'd0,   // request issued, address presented
        WAIT  = 2'd1,   // waiting for memory to drop busy
        FULL  = 2'd2,   // buffer full, no request outstanding
        DRAIN = 2'd3    // wrong-path read outstanding, response discarded
    } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/fetch_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_buffer
//  Description : Small FIFO of {pc, instr} pairs between fetch and decode.
//                flush has priority over push and pop. o_free_next reports
//                whether a slot is free after this cycle's push/pop/flush.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_buffer #(
    parameter int BUF_DEPTH = 2,
    parameter int DATA_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic              i_flush,
    input  logic [DATA_W-1:0] i_push_pc,
    input  logic [DATA_W-1:0] i_push_instr,
    output logic [DATA_W-1:0] o_head_pc,
    output logic [DATA_W-1:0] o_head_instr,
    output logic              o_full,
    output logic              o_empty,
    output logic              o_free_next
);

    localparam int              c_AW    = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam logic [c_AW:0]   c_DEPTH = (c_AW+1)'(BUF_DEPTH);

    logic [DATA_W-1:0] r_pc_mem    [BUF_DEPTH];
    logic [DATA_W-1:0] r_instr_mem [BUF_DEPTH];
    logic [c_AW-1:0]   r_rd_ptr;
    logic [c_AW-1:0]   r_wr_ptr;
    logic [c_AW:0]     r_count;
    logic [c_AW:0]     w_count_next;
    logic              w_push_ok;
    logic              w_pop_ok;

    // A push into a full buffer is accepted only when the head leaves the same cycle
    assign w_push_ok = i_push && (!o_full || i_pop) && !i_flush;
    assign w_pop_ok  = i_pop && !o_empty && !i_flush;

    assign o_full       = (r_count == c_DEPTH);
    assign o_empty      = (r_count == '0);
    assign o_head_pc    = r_pc_mem[r_rd_ptr];
    assign o_head_instr = r_instr_mem[r_rd_ptr];
    assign o_free_next  = (w_count_next < c_DEPTH);

    // Occupancy after this cycle's operations
    always_comb begin
        w_count_next = r_count;
        if (i_flush) begin
            w_count_next = '0;
        end else if (w_push_ok && !w_pop_ok) begin
            w_count_next = r_count + 1'b1;
        end else if (w_pop_ok && !w_push_ok) begin
            w_count_next = r_count - 1'b1;
        end
    end

    // Entry storage; contents beyond the valid window are don't-care
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_pc_mem[r_wr_ptr]    <= i_push_pc;
            r_instr_mem[r_wr_ptr] <= i_push_instr;
        end
    end

    // Read/write pointers and occupancy (depth is a power of two, so pointers wrap)
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= w_count_next;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : Instruction fetch stage. Issues word reads over the memory
//                enable/busy handshake, buffers {pc, instr} pairs for decode
//                and handles execute-stage redirects by flushing wrong-path
//                work. Optional statistics counters are built when the macro
//                FETCH_STATS_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
    import mips_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = MEM_START,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] mem_address,
    output logic        mem_enable,
    output logic        mem_read_write,
    input  logic [31:0] mem_data_in,
    input  logic        mem_busy,
    output logic [31:0] instr_out,
    output logic [31:0] pc_out,
    output logic        instr_valid
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0] fetch_count,
    output logic [15:0] flush_count
`endif
);

    fetch_state_t r_state;
    fetch_state_t w_state_next;
    logic [31:0]  r_fetch_pc;
    logic [31:0]  w_fetch_pc_next;
    logic [31:0]  r_mem_addr;
    logic [31:0]  w_target;
    logic [31:0]  w_head_pc;
    logic [31:0]  w_head_instr;
    logic         w_push;
    logic         w_pop;
    logic         w_full;
    logic         w_empty;
    logic         w_free_next;

    // Redirect targets are word aligned; low bits are dropped
    assign w_target = redirect_pc & ~32'h0000_0003;

    // A response landing in WAIT is captured unless a redirect kills it
    assign w_push      = (r_state == WAIT) && !mem_busy && !redirect;
    assign instr_valid = !w_empty && !reset;
    assign w_pop       = instr_valid && !stall && !redirect;

    fetch_buffer #(
        .BUF_DEPTH (BUF_DEPTH),
        .DATA_W    (INSTR_W)
    ) u_buffer (
        .clk          (clock),
        .rst          (reset),
        .i_push       (w_push),
        .i_pop        (w_pop),
        .i_flush      (redirect),
        .i_push_pc    (r_fetch_pc),
        .i_push_instr (mem_data_in),
        .o_head_pc    (w_head_pc),
        .o_head_instr (w_head_instr),
        .o_full       (w_full),
        .o_empty      (w_empty),
        .o_free_next  (w_free_next)
    );

    // Next state and next fetch PC; redirect overrides the normal flow
    always_comb begin
        w_state_next    = r_state;
        w_fetch_pc_next = r_fetch_pc;
        case (r_state)
            REQ:   w_state_next = WAIT;
            WAIT: begin
                if (!mem_busy) begin
                    w_fetch_pc_next = r_fetch_pc + 32'd4;
                    w_state_next    = w_free_next ? REQ : FULL;
                end
            end
            FULL:  if (w_pop || !w_full) w_state_next = REQ;
            DRAIN: if (!mem_busy) w_state_next = REQ;
            default: w_state_next = REQ;
        endcase
        if (redirect) begin
            w_fetch_pc_next = w_target;
            if ((r_state == WAIT || r_state == DRAIN) && mem_busy) begin
                w_state_next = DRAIN;
            end else begin
                w_state_next = REQ;
            end
        end
    end

    // State, fetch PC and the held memory address (frozen while draining)
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= REQ;
            r_fetch_pc <= RESET_PC;
            r_mem_addr <= RESET_PC;
        end else begin
            r_state    <= w_state_next;
            r_fetch_pc <= w_fetch_pc_next;
            if (w_state_next != DRAIN) begin
                r_mem_addr <= w_fetch_pc_next;
            end
        end
    end

    // Memory request and decode-facing outputs
    always_comb begin
        mem_enable     = !reset && (r_state != FULL);
        mem_address    = r_mem_addr;
        mem_read_write = 1'b1;
        pc_out         = instr_valid ? w_head_pc    : 32'h0;
        instr_out      = instr_valid ? w_head_instr : NOP_INSTR;
    end

`ifdef FETCH_STATS_EN
    logic [31:0] r_fetch_count;
    logic [15:0] r_flush_count;
    logic        w_discard;

    // A redirect discards work if the buffer holds entries or a read is outstanding
    assign w_discard = redirect && (!w_empty || r_state == WAIT || r_state == REQ);

    // Saturating capture and flush counters
    always_ff @(posedge clock) begin
        if (reset) begin
            r_fetch_count <= '0;
            r_flush_count <= '0;
        end else begin
            if (w_push && (r_fetch_count != '1)) r_fetch_count <= r_fetch_count + 1'b1;
            if (w_discard && (r_flush_count != '1)) r_flush_count <= r_flush_count + 1'b1;
        end
    end

    assign fetch_count = r_fetch_count;
    assign flush_count = r_flush_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_unit
//  Description : Scoreboard bench for fetch_unit with a simple memory model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] mem_address;
    logic        mem_enable;
    logic        mem_read_write;
    logic [31:0] mem_data_in;
    logic        mem_busy;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
    logic        instr_valid;
`ifdef FETCH_STATS_EN
    logic [31:0] fetch_count;
    logic [15:0] flush_count;
`endif

    int          checks = 0;
    int          errors = 0;
    int          busy_lat = 0;
    logic [63:0] exp_q[$];

    fetch_unit dut (
        .clock          (clock),
        .reset          (reset),
        .stall          (stall),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .mem_address    (mem_address),
        .mem_enable     (mem_enable),
        .mem_read_write (mem_read_write),
        .mem_data_in    (mem_data_in),
        .mem_busy       (mem_busy),
        .instr_out      (instr_out),
        .pc_out         (pc_out),
        .instr_valid    (instr_valid)
`ifdef FETCH_STATS_EN
        ,
        .fetch_count    (fetch_count),
        .flush_count    (flush_count)
`endif
    );

    always #5 clock = ~clock;

    // Memory image: three hand-placed words, everything else derived from the address
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h8002_0000: mem_word = 32'h8C08_0000;
            32'h8002_0004: mem_word = 32'h0109_4020;
            32'h8002_0008: mem_word = 32'h0800_0000;
            default:       mem_word = a ^ 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Expected stream from a start PC, replacing anything still pending
    task automatic sb_restart(input logic [31:0] start);
        logic [31:0] pc;
        exp_q.delete();
        for (int i = 0; i < 16; i++) begin
            pc = start + 32'(4 * i);
            exp_q.push_back({pc, mem_word(pc)});
        end
    endtask

    // Two reset edges; outputs must be idle while reset is high
    task automatic apply_reset(input int lat, input logic st);
        reset    = 1'b1;
        redirect = 1'b0;
        stall    = st;
        busy_lat = lat;
        sb_restart(32'h8002_0000);
        tick();
        tick();
        chk("rst_valid",  {31'd0, instr_valid}, 32'd0);
        chk("rst_enable", {31'd0, mem_enable},  32'd0);
        chk("rst_pc_out", pc_out, 32'h0);
        chk("rst_instr",  instr_out, 32'h0);
        reset = 1'b0;
        #1;
    endtask

    // Memory model: busy for busy_lat cycles of each transaction, then data
    initial begin
        logic        prev_hold;
        logic [31:0] prev_addr;
        int          cnt;
        prev_hold   = 1'b0;
        prev_addr   = '0;
        cnt         = 0;
        mem_busy    = 1'b0;
        mem_data_in = '0;
        forever begin
            @(negedge clock);
            if (mem_enable) begin
                if (prev_hold) chk("addr_hold", mem_address, prev_addr);
                mem_data_in = mem_word(mem_address);
                if (cnt < busy_lat) begin
                    mem_busy = 1'b1;
                    cnt++;
                end else begin
                    mem_busy = 1'b0;
                    cnt = 0;
                end
                prev_hold = mem_busy;
                prev_addr = mem_address;
            end else begin
                mem_busy  = 1'b0;
                cnt       = 0;
                prev_hold = 1'b0;
            end
        end
    end

    // Monitor: every entry decode consumes must be the next expected one
    initial begin
        logic [63:0] exp;
        forever begin
            @(negedge clock);
            if (instr_valid && !stall && !redirect && !reset) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_extra: got pc=%h instr=%h, expected no entry", pc_out, instr_out);
                end else begin
                    exp = exp_q.pop_front();
                    if ({pc_out, instr_out} !== exp) begin
                        errors++;
                        $display("FAIL sb_entry: got pc=%h instr=%h, expected pc=%h instr=%h",
                                 pc_out, instr_out, exp[63:32], exp[31:0]);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1);
    end

    initial begin
        reset       = 1'b1;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;

        // Streaming after reset, memory never busy
        apply_reset(0, 1'b0);
        chk("c0_enable", {31'd0, mem_enable}, 32'd1);
        chk("c0_addr",   mem_address, 32'h8002_0000);
        chk("rw_tied",   {31'd0, mem_read_write}, 32'd1);
        tick();
        chk("c1_valid",  {31'd0, instr_valid}, 32'd0);
        tick();
        chk("c2_valid",  {31'd0, instr_valid}, 32'd1);
        chk("c2_pc",     pc_out, 32'h8002_0000);
        chk("c2_instr",  instr_out, 32'h8C08_0000);
        repeat (8) tick();

        // Decode stalled: buffer fills, requests stop, resume at the next PC
        apply_reset(0, 1'b1);
        repeat (10) tick();
        chk("full_enable", {31'd0, mem_enable}, 32'd0);
        chk("full_valid",  {31'd0, instr_valid}, 32'd1);
        chk("full_head",   pc_out, 32'h8002_0000);
        stall = 1'b0;
        tick();
        chk("resume_enable", {31'd0, mem_enable}, 32'd1);
        chk("resume_addr",   mem_address, 32'h8002_0008);
        chk("resume_valid",  {31'd0, instr_valid}, 32'd1);
        tick();
        chk("empty_valid",   {31'd0, instr_valid}, 32'd0);
        chk("empty_pc",      pc_out, 32'h0);
        chk("empty_instr",   instr_out, 32'h0);
        repeat (4) tick();

        // Slow memory: capture on the first not-busy cycle only
        apply_reset(3, 1'b0);
        repeat (3) tick();
        chk("busy_valid_c3", {31'd0, instr_valid}, 32'd0);
        tick();
        chk("busy_valid_c4", {31'd0, instr_valid}, 32'd1);
        chk("busy_pc_c4",    pc_out, 32'h8002_0000);
        repeat (16) tick();

        // Redirect while a read is in flight: drain, then fetch the aligned target
        apply_reset(3, 1'b0);
        tick();
        redirect    = 1'b1;
        redirect_pc = 32'h8002_0043;
        sb_restart(32'h8002_0040);
        tick();
        redirect = 1'b0;
        chk("drain_enable", {31'd0, mem_enable}, 32'd1);
        chk("drain_addr",   mem_address, 32'h8002_0000);
        chk("drain_valid",  {31'd0, instr_valid}, 32'd0);
        tick();
        tick();
        chk("post_drain_addr", mem_address, 32'h8002_0040);
        repeat (14) tick();

        // Redirect coinciding with a pop and a capture
        apply_reset(0, 1'b1);
        repeat (3) tick();
        chk("pre_redir_valid", {31'd0, instr_valid}, 32'd1);
        stall       = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'h8002_1000;
        sb_restart(32'h8002_1000);
        tick();
        redirect = 1'b0;
        chk("redir_valid",  {31'd0, instr_valid}, 32'd0);
        chk("redir_enable", {31'd0, mem_enable}, 32'd1);
        chk("redir_addr",   mem_address, 32'h8002_1000);
        repeat (8) tick();

        // Reset in the middle of a busy read with an entry buffered
        apply_reset(3, 1'b1);
        repeat (5) tick();
        chk("mid_valid", {31'd0, instr_valid}, 32'd1);
        reset = 1'b1;
        sb_restart(32'h8002_0000);
        #1;
        chk("mid_rst_enable", {31'd0, mem_enable}, 32'd0);
        chk("mid_rst_valid",  {31'd0, instr_valid}, 32'd0);
        tick();
        reset = 1'b0;
        stall = 1'b0;
        #1;
        chk("after_rst_valid",  {31'd0, instr_valid}, 32'd0);
        chk("after_rst_enable", {31'd0, mem_enable}, 32'd1);
        chk("after_rst_addr",   mem_address, 32'h8002_0000);
`ifdef FETCH_STATS_EN
        chk("fetch_count_rst", fetch_count, 32'd0);
        chk("flush_count_rst", {16'd0, flush_count}, 32'd0);
`endif
        repeat (12) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
